inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_if.sv | 29 ++
 rtl/inst_fetch.sv | 119 +++++++++++
 tb/tb_inst_fetch.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// Bundles the two handshakes of the fetch stage:
//   instruction memory : ImemReq/ImemAddr out, ImemGnt/ImemRvalid/ImemRdata in
//   decode             : InstValid/Inst/InstPc out, IdReady in
// master = fetch stage side, slave = memory/decode side.
// -----------------------------------------------------------------------------
interface inst_fetch_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt;
  logic        ImemRvalid;
  logic [31:0] ImemRdata;

  logic        InstValid;
  logic [31:0] Inst;
  logic [31:0] InstPc;
  logic        IdReady;

  modport master (
    output ImemReq, ImemAddr, InstValid, Inst, InstPc,
    input  ImemGnt, ImemRvalid, ImemRdata, IdReady
  );

  modport slave (
    input  ImemReq, ImemAddr, InstValid, Inst, InstPc,
    output ImemGnt, ImemRvalid, ImemRdata, IdReady
  );
endinterface

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage with a credit-controlled request path and a 2-entry
// instruction buffer feeding decode.
//
// Ports:
//   Clk        : clock, all state updates on its rising edge
//   ReSet      : synchronous active-high reset
//   Redirect   : one-cycle pulse from the PC stage (taken branch / jump)
//   RedirectPc : new fetch address, valid with Redirect
//   bus        : inst_fetch_if.master (memory request/response + decode handshake)
//
// Parameters:
//   RESET_PC : fetch address after reset
//   DEPTH    : instruction buffer entries (only 2 is supported)
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 2
) (
  input  logic        Clk,
  input  logic        ReSet,
  input  logic        Redirect,
  input  logic [31:0] RedirectPc,
  inst_fetch_if.master bus
);

  localparam logic [31:0] WordMask = 32'hFFFF_FFFC;

  logic [31:0] FetchPc;      // next address to request
  logic [1:0]  Outstanding;  // accepted requests whose response has not returned
  logic [1:0]  Drop;         // of those, how many are stale (pre-redirect)
  logic [1:0]  Count;        // buffer occupancy

  logic [31:0] HeadInst, HeadPc;  // buffer entry 0 (head, drives decode)
  logic [31:0] Ent1Inst, Ent1Pc;  // buffer entry 1

  logic [2:0]  Credit;
  logic        ReqOk;
  logic        Accept;
  logic        Push;
  logic        Pop;
  logic        Discard;
  logic [1:0]  Live;
  logic [31:0] FetchedPc;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here unconditionally), so no latch can be inferred.
  always_comb begin
    // Outstanding requests and buffered words share the same DEPTH slots, so
    // a response always has room when it returns.
    Credit  = {1'b0, Outstanding} + {1'b0, Count};
    ReqOk   = !ReSet && !Redirect && (Credit < 3'(DEPTH));
    Accept  = ReqOk && bus.ImemGnt;
    Pop     = (Count != 2'd0) && bus.IdReady;
    Push    = bus.ImemRvalid && (Drop == 2'd0);
    Discard = bus.ImemRvalid && (Drop != 2'd0);
    // Live requests are contiguous and end just below FetchPc, so the oldest
    // live one (the one now returning) sits Live words below it.
    Live      = Outstanding - Drop;
    FetchedPc = FetchPc - {28'd0, Live, 2'b00};
  end

  assign bus.ImemReq   = ReqOk;
  assign bus.ImemAddr  = FetchPc & WordMask;
  assign bus.InstValid = (Count != 2'd0);
  assign bus.Inst      = HeadInst;
  assign bus.InstPc    = HeadPc;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (ReSet) begin
      FetchPc     <= RESET_PC & WordMask;
      Outstanding <= 2'd0;
      Drop        <= 2'd0;
      Count       <= 2'd0;
      HeadInst    <= 32'd0;
      HeadPc      <= 32'd0;
    end else if (Redirect) begin
      // Everything still in flight is stale; a response arriving right now is
      // discarded here, so it is not counted in Drop.
      FetchPc     <= RedirectPc & WordMask;
      Outstanding <= Outstanding - {1'b0, bus.ImemRvalid};
      Drop        <= Outstanding - {1'b0, bus.ImemRvalid};
      Count       <= 2'd0;
    end else begin
      if (Accept) begin
        FetchPc <= FetchPc + 32'd4;
      end
      Outstanding <= Outstanding + {1'b0, Accept} - {1'b0, bus.ImemRvalid};
      if (Discard) begin
        Drop <= Drop - 2'd1;
      end
      Count <= Count + {1'b0, Push} - {1'b0, Pop};

      // Head takes the new word when the buffer is (or becomes) empty,
      // otherwise it advances from entry 1 on a pop.
      if (Push && ((Count == 2'd0) || ((Count == 2'd1) && Pop))) begin
        HeadInst <= bus.ImemRdata;
        HeadPc   <= FetchedPc;
      end else if (Pop) begin
        HeadInst <= Ent1Inst;
        HeadPc   <= Ent1Pc;
      end
    end
  end

  // NOTE: entry 1 payload carries no reset; Count alone says whether it holds
  // anything, so clearing the data would only add reset fan-out.
  always_ff @(posedge Clk) begin
    if (!ReSet && !Redirect && Push &&
        (((Count == 2'd1) && !Pop) || ((Count == 2'd2) && Pop))) begin
      Ent1Inst <= bus.ImemRdata;
      Ent1Pc   <= FetchedPc;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Self-checking bench for inst_fetch. The memory is an in-order queue with a
// per-request latency. The reference is a queue of the words decode should
// see: in-flight requests are marked stale on a redirect, and only fresh
// responses enter the expected buffer. Request permission is recomputed from
// the slot rule (in-flight + buffered < 2).
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        Clk;
  logic        ReSet;
  logic        Redirect;
  logic [31:0] RedirectPc;

  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .Clk        (Clk),
    .ReSet      (ReSet),
    .Redirect   (Redirect),
    .RedirectPc (RedirectPc),
    .bus        (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  mreq_t       mq[$];      // memory: accepted requests in order
  logic [31:0] fifo[$];    // expected buffer contents (PCs)
  logic [31:0] pops[$];    // PCs consumed by decode, for directed checks
  int          pop_cyc[$];
  logic [31:0] exp_fetch;
  int          cyc;
  int          last_due;
  bit          reset_known;

  int errs;
  int checks;

  // observed outputs of the latest cycle
  logic        obs_req, obs_valid, obs_rvalid;
  logic [31:0] obs_addr, obs_inst, obs_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, observe #1 later, update the model for
  // what the coming posedge does.
  task automatic cycle(input logic rst, input logic redir, input logic [31:0] rpc,
                       input logic gnt, input logic rdy, input int lat);
    logic        dlv;
    logic [31:0] dlv_addr;
    bit          dlv_stale;
    int          outst;
    logic        exp_req;
    int          due;
    @(negedge Clk);
    ReSet       = rst;
    Redirect    = redir;
    RedirectPc  = rpc;
    bus.ImemGnt = gnt;
    bus.IdReady = rdy;
    dlv = 1'b0; dlv_addr = 32'd0; dlv_stale = 1'b0;
    if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
      dlv       = 1'b1;
      dlv_addr  = mq[0].addr;
      dlv_stale = mq[0].stale;
      void'(mq.pop_front());
    end
    bus.ImemRvalid = dlv;
    bus.ImemRdata  = dlv ? memf(dlv_addr) : 32'd0;
    #1;
    obs_req    = bus.ImemReq;
    obs_addr   = bus.ImemAddr;
    obs_valid  = bus.InstValid;
    obs_inst   = bus.Inst;
    obs_pc     = bus.InstPc;
    obs_rvalid = dlv;

    if (reset_known) begin
      outst   = mq.size() + (dlv ? 1 : 0);
      exp_req = !rst && !redir && ((outst + fifo.size()) < 2);
      check("imem_req", {31'd0, obs_req}, {31'd0, exp_req});
      if (obs_req) check("imem_addr", obs_addr, exp_fetch);
      check("inst_valid", {31'd0, obs_valid}, {31'd0, fifo.size() != 0});
      if (fifo.size() != 0) begin
        check("inst_pc", obs_pc, fifo[0]);
        check("inst_word", obs_inst, memf(fifo[0]));
      end
    end

    if (rst) begin
      mq.delete();
      fifo.delete();
      exp_fetch   = RST_PC;
      last_due    = 0;
      reset_known = 1'b1;
    end else if (redir) begin
      foreach (mq[i]) mq[i].stale = 1'b1;
      fifo.delete();
      exp_fetch = rpc & 32'hFFFF_FFFC;
    end else begin
      if (obs_req && gnt) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{addr: exp_fetch, due: due, stale: 1'b0});
        exp_fetch = exp_fetch + 32'd4;
      end
      if (obs_valid && rdy && fifo.size() != 0) begin
        pops.push_back(fifo[0]);
        pop_cyc.push_back(cyc);
        void'(fifo.pop_front());
      end
      if (dlv && !dlv_stale) fifo.push_back(dlv_addr);
      if (fifo.size() > 2) begin
        check("buffer_overflow", fifo.size(), 2);
        void'(fifo.pop_back());
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1);
  endtask

  task automatic run(input int n, input int lat, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, rdy, lat);
  endtask

  task automatic expect_pops(input string tag, input int idx, input logic [31:0] pc);
    if (pops.size() > idx) check(tag, pops[idx], pc);
    else check({tag, "_missing"}, pops.size(), idx + 1);
  endtask

  initial begin
    errs = 0; checks = 0; cyc = 0; last_due = 0; reset_known = 1'b0;
    exp_fetch = RST_PC;
    ReSet = 1'b1; Redirect = 1'b0; RedirectPc = 32'd0;
    bus.ImemGnt = 1'b0; bus.ImemRvalid = 1'b0; bus.ImemRdata = 32'd0; bus.IdReady = 1'b0;

    // reset state
    do_reset();
    check("rst_inst", obs_inst, 32'd0);
    check("rst_inst_pc", obs_pc, 32'd0);
    check("rst_valid", {31'd0, obs_valid}, 32'd0);
    check("rst_req", {31'd0, obs_req}, 32'd0);

    // first request right after release, then a 1-cycle memory stream
    pops.delete(); pop_cyc.delete();
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1);
    check("first_req", {31'd0, obs_req}, 32'd1);
    check("first_addr", obs_addr, 32'h0000_3000);
    run(9, 1, 1'b1);
    expect_pops("stream_pc0", 0, 32'h0000_3000);
    expect_pops("stream_pc1", 1, 32'h0000_3004);
    expect_pops("stream_pc2", 2, 32'h0000_3008);
    if (pop_cyc.size() > 1) check("stream_back_to_back", pop_cyc[1] - pop_cyc[0], 1);

    // decode stall: buffer fills with two words, requests stop
    do_reset();
    run(6, 1, 1'b0);
    check("stall_req", {31'd0, obs_req}, 32'd0);
    check("stall_valid", {31'd0, obs_valid}, 32'd1);
    check("stall_head", obs_pc, 32'h0000_3000);
    pops.delete(); pop_cyc.delete();
    run(10, 1, 1'b1);
    expect_pops("unstall_pc0", 0, 32'h0000_3000);
    expect_pops("unstall_pc1", 1, 32'h0000_3004);
    expect_pops("unstall_pc2", 2, 32'h0000_3008);
    expect_pops("unstall_pc3", 3, 32'h0000_300C);

    // grant withheld three cycles: request held stable
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1);
      check("hold_req", {31'd0, obs_req}, 32'd1);
      check("hold_addr", obs_addr, 32'h0000_3000);
    end
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1);
    check("hold_accept_addr", obs_addr, 32'h0000_3000);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1);
    check("after_accept_addr", obs_addr, 32'h0000_3004);

    // redirect with two requests in flight: both stale
    do_reset();
    run(2, 3, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_3101, 1'b1, 1'b1, 3);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 3);
    check("redir_addr", obs_addr, 32'h0000_3100);
    pops.delete(); pop_cyc.delete();
    run(15, 3, 1'b1);
    expect_pops("redir_first_pc", 0, 32'h0000_3100);

    // redirect coincident with a response and a pop, latency 3
    do_reset();
    run(4, 3, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_3200, 1'b1, 1'b1, 3);
    check("coinc_rvalid", {31'd0, obs_rvalid}, 32'd1);
    check("coinc_valid", {31'd0, obs_valid}, 32'd1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 3);
    check("coinc_empty", {31'd0, obs_valid}, 32'd0);
    check("coinc_fetch", obs_addr, 32'h0000_3200);

    // address wrap
    do_reset();
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1);
    check("wrap_top", obs_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1);
    check("wrap_zero", obs_addr, 32'h0000_0000);

    // back-to-back redirects: last wins, all earlier responses dropped
    do_reset();
    run(2, 4, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_5000, 1'b1, 1'b1, 4);
    cycle(1'b0, 1'b1, 32'h0000_6004, 1'b1, 1'b1, 4);
    pops.delete(); pop_cyc.delete();
    run(15, 4, 1'b1);
    expect_pops("b2b_first_pc", 0, 32'h0000_6004);

    // reset mid-operation discards everything in flight
    run(2, 4, 1'b1);
    do_reset();
    pops.delete(); pop_cyc.delete();
    run(12, 2, 1'b1);
    expect_pops("midrst_first_pc", 0, RST_PC);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 39) == 0,
            $urandom(),
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 3) != 0,
            int'($urandom_range(1, 4)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
